vdp99_port_arbiter: RTL and testbench

Shares the single pxclk-domain CPU port of the vdp99 core between two requesters: port A (the synchronized Z80 bus bridge) and port B (a VRAM block-copy/DMA engine). Requests are arbitrated round-robin, and accesses are issued as one-cycle `wr_tick`/`rd_tick` pulses with a guaranteed minimum spacing. The block also protects the VDP's two-byte control-port sequence so that the other requester can never split it. It sits between the requesters and the vdp99 instance, with all signals in the pxclk domain.

---
 rtl/vdp99_port_arbiter_if.sv | 14 +
 rtl/vdp99_port_arbiter.sv | 128 ++++++++++++
 tb/tb_vdp99_port_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp99_port_arbiter_if.sv
// rtl/vdp99_port_arbiter_if.sv - one requester's handshake into the vdp99 port arbiter
interface vdp99_port_arbiter_if;
  logic       req;
  logic       we;
  logic       mode;
  logic [7:0] wdata;
  logic       lock;
  logic       ack;
  logic       rvalid;
  logic [7:0] rdata;

  modport master (output req, we, mode, wdata, lock, input ack, rvalid, rdata);
  modport slave  (input req, we, mode, wdata, lock, output ack, rvalid, rdata);
endinterface

// File: rtl/vdp99_port_arbiter.sv
// rtl/vdp99_port_arbiter.sv - round-robin sharing of the vdp99 CPU port between two requesters
module vdp99_port_arbiter #(
  parameter int GAP = 8
) (
  input  logic                       pxclk,
  input  logic                       reset,
  vdp99_port_arbiter_if.slave        a,
  vdp99_port_arbiter_if.slave        b,
  output logic                       vdp_wr_tick,
  output logic                       vdp_rd_tick,
  output logic                       vdp_mode,
  output logic [7:0]                 vdp_din,
  input  logic [7:0]                 vdp_dout,
  output logic                       busy,
  output logic                       pair_pend
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // ISSUE + WAIT(GAP-2) + IDLE(1) gives exactly GAP cycles between ticks
  localparam logic [7:0] WAIT_LOAD = 8'(GAP - 3);

  state_t     state;
  logic [7:0] cnt;
  logic       owner;       // 0 = A, 1 = B
  logic       last_owner;
  logic       pair_owner;
  logic       cur_we;
  logic       a_ack_q, b_ack_q, a_rvalid_q, b_rvalid_q;
  logic [7:0] a_rdata_q, b_rdata_q;

  logic       a_elig, b_elig, grant_b;
  logic       sel_we, sel_mode;
  logic [7:0] sel_wdata;

  always_comb begin
    a_elig = a.req;
    b_elig = b.req;
    if (pair_pend) begin
      a_elig = a.req && !pair_owner;
      b_elig = b.req && pair_owner;
    end else if (last_owner ? b.lock : a.lock) begin
      a_elig = a.req && !last_owner;
      b_elig = b.req && last_owner;
    end
    grant_b   = b_elig && (!a_elig || !last_owner);
    sel_we    = grant_b ? b.we    : a.we;
    sel_mode  = grant_b ? b.mode  : a.mode;
    sel_wdata = grant_b ? b.wdata : a.wdata;
  end

  always_ff @(posedge pxclk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      pair_owner  <= 1'b0;
      pair_pend   <= 1'b0;
      cur_we      <= 1'b0;
      vdp_wr_tick <= 1'b0;
      vdp_rd_tick <= 1'b0;
      vdp_mode    <= 1'b0;
      vdp_din     <= 8'h00;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= 8'h00;
      b_rdata_q   <= 8'h00;
    end else begin
      vdp_wr_tick <= 1'b0;
      vdp_rd_tick <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (a_elig || b_elig) begin
            owner       <= grant_b;
            last_owner  <= grant_b;
            cur_we      <= sel_we;
            vdp_mode    <= sel_mode;
            vdp_din     <= sel_wdata;
            vdp_wr_tick <= sel_we;
            vdp_rd_tick <= !sel_we;
            a_ack_q     <= !grant_b;
            b_ack_q     <= grant_b;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!cur_we) begin
            if (owner) begin
              b_rdata_q  <= vdp_dout;
              b_rvalid_q <= 1'b1;
            end else begin
              a_rdata_q  <= vdp_dout;
              a_rvalid_q <= 1'b1;
            end
          end
          // Track the VDP's two-byte control latch so the other side cannot split it
          if (!pair_pend && vdp_mode && cur_we) begin
            pair_pend  <= 1'b1;
            pair_owner <= owner;
          end else if (pair_pend && owner == pair_owner) begin
            pair_pend <= 1'b0;
          end
          cnt   <= WAIT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 8'd0) state <= IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign a.ack    = a_ack_q;
  assign b.ack    = b_ack_q;
  assign a.rvalid = a_rvalid_q;
  assign b.rvalid = b_rvalid_q;
  assign a.rdata  = a_rdata_q;
  assign b.rdata  = b_rdata_q;
endmodule

// File: tb/tb_vdp99_port_arbiter.sv
// tb/tb_vdp99_port_arbiter.sv - self-checking bench for vdp99_port_arbiter
module tb_vdp99_port_arbiter;
  localparam int GAP = 8;

  logic pxclk = 1'b0;
  logic reset = 1'b0;
  always #5 pxclk = ~pxclk;

  vdp99_port_arbiter_if a_if ();
  vdp99_port_arbiter_if b_if ();
  vdp99_port_arbiter_if a3_if ();
  vdp99_port_arbiter_if b3_if ();

  logic       wr_tick, rd_tick, vmode, busy, pair_pend;
  logic [7:0] vdin;
  logic [7:0] vdout = 8'h00;
  logic       wr3, rd3, vmode3, busy3, pair3;
  logic [7:0] vdin3;

  vdp99_port_arbiter #(.GAP(GAP)) dut (
    .pxclk(pxclk), .reset(reset), .a(a_if), .b(b_if),
    .vdp_wr_tick(wr_tick), .vdp_rd_tick(rd_tick), .vdp_mode(vmode), .vdp_din(vdin),
    .vdp_dout(vdout), .busy(busy), .pair_pend(pair_pend)
  );

  vdp99_port_arbiter #(.GAP(3)) dut3 (
    .pxclk(pxclk), .reset(reset), .a(a3_if), .b(b3_if),
    .vdp_wr_tick(wr3), .vdp_rd_tick(rd3), .vdp_mode(vmode3), .vdp_din(vdin3),
    .vdp_dout(8'h00), .busy(busy3), .pair_pend(pair3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each granted access owns the port for GAP cycles counted from its decision cycle
  int         cyc = 0;
  int         dec_cyc = 0;
  bit         active = 0;
  bit         m_owner, m_we, m_mode;
  logic [7:0] m_wdata;
  bit         m_last = 1, m_pair = 0, m_pair_owner = 0;
  bit         e_wr, e_rd, e_aack, e_back, e_arv, e_brv, e_busy, e_pair, e_mode;
  logic [7:0] e_din = 8'h00, e_ard = 8'h00, e_brd = 8'h00;

  task automatic model_step();
    int ph;
    bit ae, be, gb, lk;
    if (!reset) begin
      active = 0; m_last = 1; m_pair = 0; m_pair_owner = 0;
      e_mode = 0; e_din = 8'h00; e_ard = 8'h00; e_brd = 8'h00;
    end else begin
      ph = cyc - dec_cyc;
      if (active && ph == 1) begin
        if (!m_we) begin
          if (m_owner) e_brd = vdout;
          else         e_ard = vdout;
        end
        if (!m_pair && m_mode && m_we) begin
          m_pair = 1; m_pair_owner = m_owner;
        end else if (m_pair && m_owner == m_pair_owner) begin
          m_pair = 0;
        end
      end
      if (!active || ph >= GAP) begin
        ae = a_if.req; be = b_if.req;
        lk = m_last ? b_if.lock : a_if.lock;
        if (m_pair) begin
          ae = ae && !m_pair_owner; be = be && m_pair_owner;
        end else if (lk) begin
          ae = ae && !m_last; be = be && m_last;
        end
        if (ae || be) begin
          gb = (ae && be) ? !m_last : be;
          m_owner = gb; m_last = gb;
          m_we    = gb ? b_if.we    : a_if.we;
          m_mode  = gb ? b_if.mode  : a_if.mode;
          m_wdata = gb ? b_if.wdata : a_if.wdata;
          e_mode  = m_mode; e_din = m_wdata;
          dec_cyc = cyc; active = 1;
        end
      end
    end
    cyc++;
    ph = cyc - dec_cyc;
    e_wr   = active && ph == 1 && m_we;
    e_rd   = active && ph == 1 && !m_we;
    e_aack = active && ph == 1 && !m_owner;
    e_back = active && ph == 1 && m_owner;
    e_arv  = active && ph == 2 && !m_we && !m_owner;
    e_brv  = active && ph == 2 && !m_we && m_owner;
    e_busy = active && ph >= 1 && ph <= GAP - 1;
    e_pair = m_pair;
  endtask

  initial forever begin
    @(posedge pxclk);
    model_step();
  end

  initial forever begin
    @(negedge pxclk);
    if (cyc > 0) begin
      chk1("wr_tick", wr_tick, e_wr);
      chk1("rd_tick", rd_tick, e_rd);
      chk1("a_ack", a_if.ack, e_aack);
      chk1("b_ack", b_if.ack, e_back);
      chk1("a_rvalid", a_if.rvalid, e_arv);
      chk1("b_rvalid", b_if.rvalid, e_brv);
      chk8("a_rdata", a_if.rdata, e_ard);
      chk8("b_rdata", b_if.rdata, e_brd);
      chk1("vdp_mode", vmode, e_mode);
      chk8("vdp_din", vdin, e_din);
      chk1("busy", busy, e_busy);
      chk1("pair_pend", pair_pend, e_pair);
    end
  end

  // Tick log: negedge index of every tick and whether B owned it
  int ncyc = 0;
  int tq[$];
  bit tbq[$];
  int t3q[$];

  initial forever begin
    @(negedge pxclk);
    ncyc++;
    if (wr_tick || rd_tick) begin
      tq.push_back(ncyc);
      tbq.push_back(b_if.ack);
    end
    if (wr3) t3q.push_back(ncyc);
  end

  typedef struct packed {
    logic       req;
    logic       we;
    logic       mode;
    logic       lock;
    logic [7:0] wdata;
  } rq_t;

  rq_t ra = '0;
  rq_t rb = '0;

  function automatic rq_t next_rq(input rq_t cur, input logic ack);
    rq_t n = cur;
    bit  fresh = 0;
    if (cur.req && ack)   begin n.req = ($urandom_range(1, 0) == 1); fresh = n.req; end
    else if (cur.req)     begin if ($urandom_range(63, 0) == 0) n.req = 1'b0; end
    else if ($urandom_range(2, 0) == 0) begin n.req = 1'b1; fresh = 1; end
    if (fresh) begin
      n.we    = ($urandom_range(1, 0) == 1);
      n.mode  = ($urandom_range(1, 0) == 1);
      n.wdata = 8'($urandom);
    end
    if ($urandom_range(9, 0) == 0) n.lock = ~cur.lock;
    return n;
  endfunction

  task automatic idle_all();
    a_if.req = 0;  a_if.we = 0;  a_if.mode = 0;  a_if.wdata = 8'h00;  a_if.lock = 0;
    b_if.req = 0;  b_if.we = 0;  b_if.mode = 0;  b_if.wdata = 8'h00;  b_if.lock = 0;
    a3_if.req = 0; a3_if.we = 0; a3_if.mode = 0; a3_if.wdata = 8'h00; a3_if.lock = 0;
    b3_if.req = 0; b3_if.we = 0; b3_if.mode = 0; b3_if.wdata = 8'h00; b3_if.lock = 0;
  endtask

  task automatic pulse_reset();
    idle_all();
    @(negedge pxclk);
    reset = 0;
    @(negedge pxclk);
    reset = 1;
    @(negedge pxclk);
    tq.delete(); tbq.delete(); t3q.delete();
  endtask

  task automatic wait_ack(input bit is_b, input string name);
    int n = 0;
    n_vec++;
    do begin
      @(negedge pxclk);
      n++;
    end while (!(is_b ? b_if.ack : a_if.ack) && n < 4 * GAP);
    if (!(is_b ? b_if.ack : a_if.ack)) begin
      n_err++;
      $display("FAIL %s: no ack after %0d cycles, required ack within %0d", name, n, 4 * GAP);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    bit prev_a, prev_b;
    idle_all();
    reset = 0;
    @(negedge pxclk);
    @(negedge pxclk);
    reset = 1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_pair", pair_pend, 1'b0);
    chk1("rst_wr", wr_tick, 1'b0);
    chk1("rst_rd", rd_tick, 1'b0);
    chk1("rst_mode", vmode, 1'b0);
    chk8("rst_din", vdin, 8'h00);
    chk8("rst_ardata", a_if.rdata, 8'h00);
    chk8("rst_brdata", b_if.rdata, 8'h00);

    // A-only write, then a second write held back to GAP
    pulse_reset();
    a_if.req = 1; a_if.we = 1; a_if.mode = 0; a_if.wdata = 8'h5A;
    @(negedge pxclk);
    chk1("aw_tick", wr_tick, 1'b1);
    chk1("aw_ack", a_if.ack, 1'b1);
    chk8("aw_din", vdin, 8'h5A);
    chk1("aw_mode", vmode, 1'b0);
    a_if.wdata = 8'hA5;
    wait_ack(0, "aw_second");
    a_if.req = 0;
    @(negedge pxclk);
    chki("aw_count", tq.size(), 2);
    if (tq.size() >= 2) chki("aw_spacing", tq[1] - tq[0], GAP);

    // Contention: continuous reads from both sides
    pulse_reset();
    a_if.req = 1; a_if.we = 0; a_if.mode = 0;
    b_if.req = 1; b_if.we = 0; b_if.mode = 1;
    prev_a = 0; prev_b = 0;
    repeat (6 * GAP + 2) begin
      @(negedge pxclk);
      if (prev_a) begin chk1("ct_arvalid", a_if.rvalid, 1'b1); chk8("ct_ardata", a_if.rdata, 8'h11); end
      if (prev_b) begin chk1("ct_brvalid", b_if.rvalid, 1'b1); chk8("ct_brdata", b_if.rdata, 8'h22); end
      prev_a = a_if.ack; prev_b = b_if.ack;
      vdout = a_if.ack ? 8'h11 : (b_if.ack ? 8'h22 : 8'($urandom));
    end
    a_if.req = 0; b_if.req = 0;
    chk1("ct_enough", tq.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < tq.size(); i++) begin
      chk1("ct_order", tbq[i], (i % 2) == 1);
      if (i > 0) chki("ct_spacing", tq[i] - tq[i-1], GAP);
    end

    // Pair protection: B's two control bytes are never split by A
    pulse_reset();
    b_if.req = 1; b_if.we = 1; b_if.mode = 1; b_if.wdata = 8'h00;
    wait_ack(1, "pr_b1");
    b_if.wdata = 8'h40;
    a_if.req = 1; a_if.we = 1; a_if.mode = 0; a_if.wdata = 8'h77;
    @(negedge pxclk);
    chk1("pr_set", pair_pend, 1'b1);
    wait_ack(1, "pr_b2");
    chk8("pr_b2_din", vdin, 8'h40);
    b_if.req = 0;
    @(negedge pxclk);
    chk1("pr_clear", pair_pend, 1'b0);
    wait_ack(0, "pr_a");
    a_if.req = 0;
    chki("pr_count", tq.size(), 3);
    if (tq.size() == 3) begin
      chki("pr_order", {tbq[0], tbq[1], tbq[2]}, 3'b110);
      chki("pr_a_after", tq[2] - tq[1], GAP);
    end

    // Lock: A keeps the port for 4 writes while B waits
    pulse_reset();
    a_if.req = 1; a_if.lock = 1; a_if.we = 1; a_if.mode = 0; a_if.wdata = 8'h00;
    b_if.req = 1; b_if.we = 1; b_if.mode = 0; b_if.wdata = 8'hBB;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, "lk_a");
      if (i == 3) begin a_if.req = 0; a_if.lock = 0; end
      else a_if.wdata = 8'(i + 1);
    end
    wait_ack(1, "lk_b");
    b_if.req = 0;
    chki("lk_count", tq.size(), 5);
    if (tq.size() == 5) begin
      chki("lk_order", {tbq[0], tbq[1], tbq[2], tbq[3], tbq[4]}, 5'b00001);
      for (int i = 1; i < 5; i++) chki("lk_spacing", tq[i] - tq[i-1], GAP);
    end

    // GAP=3 boundary on the second instance
    pulse_reset();
    a3_if.req = 1; a3_if.we = 1; a3_if.mode = 0; a3_if.wdata = 8'h00;
    repeat (20) begin
      @(negedge pxclk);
      if (a3_if.ack) a3_if.wdata = a3_if.wdata + 8'd1;
    end
    a3_if.req = 0;
    chk1("g3_enough", t3q.size() >= 6, 1'b1);
    for (int i = 1; i < 6 && i < t3q.size(); i++) chki("g3_spacing", t3q[i] - t3q[i-1], 3);

    // Reset during WAIT after a control write clears pair_pend
    pulse_reset();
    a_if.req = 1; a_if.we = 1; a_if.mode = 1; a_if.wdata = 8'h80;
    wait_ack(0, "rw_ctrl");
    a_if.req = 0;
    @(negedge pxclk);
    chk1("rw_pair_set", pair_pend, 1'b1);
    reset = 0;
    @(negedge pxclk);
    reset = 1;
    chk1("rw_pair_clr", pair_pend, 1'b0);
    chk1("rw_busy", busy, 1'b0);
    chk8("rw_din", vdin, 8'h00);
    chk1("rw_mode", vmode, 1'b0);

    // Reset during WAIT after a read tick
    a_if.req = 1; a_if.we = 0; a_if.mode = 0;
    wait_ack(0, "rr_read");
    vdout = 8'h99;
    a_if.req = 0;
    @(negedge pxclk);
    chk1("rr_rvalid", a_if.rvalid, 1'b1);
    chk8("rr_rdata", a_if.rdata, 8'h99);
    reset = 0;
    @(negedge pxclk);
    reset = 1;
    chk8("rr_rdata_rst", a_if.rdata, 8'h00);
    chk1("rr_busy", busy, 1'b0);
    repeat (GAP) begin
      @(negedge pxclk);
      chk1("rr_no_rvalid", a_if.rvalid, 1'b0);
      chk1("rr_no_tick", wr_tick | rd_tick, 1'b0);
    end

    // Reset landing on the ISSUE cycle suppresses rvalid entirely
    a_if.req = 1; a_if.we = 0; a_if.mode = 1;
    wait_ack(0, "ri_read");
    vdout = 8'h55;
    a_if.req = 0;
    reset = 0;
    @(negedge pxclk);
    reset = 1;
    chk1("ri_no_rvalid", a_if.rvalid, 1'b0);
    chk8("ri_rdata", a_if.rdata, 8'h00);
    chk1("ri_busy", busy, 1'b0);

    // Randomized traffic with occasional resets, checked by the model every cycle
    pulse_reset();
    ra = '0; rb = '0;
    repeat (3000) begin
      @(negedge pxclk);
      if (!reset) reset = 1;
      else if ($urandom_range(399, 0) == 0) reset = 0;
      ra = next_rq(ra, a_if.ack);
      rb = next_rq(rb, b_if.ack);
      a_if.req = ra.req; a_if.we = ra.we; a_if.mode = ra.mode; a_if.wdata = ra.wdata; a_if.lock = ra.lock;
      b_if.req = rb.req; b_if.we = rb.we; b_if.mode = rb.mode; b_if.wdata = rb.wdata; b_if.lock = rb.lock;
      vdout = 8'($urandom);
    end
    reset = 1;
    idle_all();
    repeat (GAP + 2) @(negedge pxclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
